// File: rtl/if_stage_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage.
package if_stage_pkg;

    localparam int               WORD       = 32;
    localparam logic [WORD-1:0]  NOP_INSTR  = 32'h0000_0000;
    localparam logic [WORD-1:0]  RESET_PC   = 32'h0000_0000;
    localparam int               IMEM_BYTES = 168;

    typedef enum logic [1:0] {
        PC_SEQ      = 2'd0,
        PC_REDIRECT = 2'd1,
        PC_HOLD     = 2'd2
    } pc_sel_e;

    function automatic logic [WORD-1:0] word_align(input logic [WORD-1:0] addr);
        return {addr[WORD-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: reset and bubble load a NOP, load captures a fetched word, otherwise hold.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int W = WORD
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         bubble,
    input  logic [W-1:0] instr_in,
    input  logic [W-1:0] pc4_in,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc4,
    output logic         valid
);

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            instr <= W'(NOP_INSTR);
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, end-of-program detection,
// misaligned-redirect flag and fetch counter, feeding the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int               W          = WORD,
    parameter logic [W-1:0]     RST_PC     = W'(RESET_PC),
    parameter int               IMEM_LIMIT = IMEM_BYTES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [W-1:0] branch_target,
    input  logic         jump,
    input  logic [W-1:0] jump_target,
    output logic [W-1:0] imem_addr,
    input  logic [W-1:0] imem_instr,
    output logic [W-1:0] if_id_instr,
    output logic [W-1:0] if_id_pc4,
    output logic         if_id_valid,
    output logic         halted,
    output logic         misalign_err,
    output logic [W-1:0] fetch_count
);

    localparam logic [W-1:0] IMEM_END = W'(IMEM_LIMIT);

    logic [W-1:0] pc;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] target_raw;
    logic [W-1:0] target;
    logic         redirect;
    pc_sel_e      pc_sel;
    logic         load;
    logic         bubble;

    assign imem_addr  = pc;
    assign pc_plus4   = pc + W'(4);
    assign halted     = (pc >= IMEM_END);
    assign redirect   = branch_taken | jump;
    assign target_raw = branch_taken ? branch_target : jump_target;
    assign target     = {target_raw[W-1:2], 2'b00};

    // Priority below reset: redirect > stall > halted > sequential.
    always_comb begin
        pc_sel = PC_SEQ;
        load   = 1'b0;
        bubble = 1'b0;
        if (redirect) begin
            pc_sel = PC_REDIRECT;
            bubble = 1'b1;
        end else if (stall) begin
            pc_sel = PC_HOLD;
        end else if (halted) begin
            pc_sel = PC_HOLD;
            bubble = 1'b1;
        end else begin
            load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RST_PC;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            case (pc_sel)
                PC_REDIRECT: pc <= target;
                PC_SEQ:      pc <= pc_plus4;
                default:     pc <= pc;
            endcase
            if (redirect && (target_raw[1:0] != 2'b00))
                misalign_err <= 1'b1;
            if (load)
                fetch_count <= fetch_count + W'(1);
        end
    end

    if_id_reg #(.W(W)) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .bubble   (bubble),
        .instr_in (imem_instr),
        .pc4_in   (pc_plus4),
        .instr    (if_id_instr),
        .pc4      (if_id_pc4),
        .valid    (if_id_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand sequences and randomized run vs a model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] if_id_instr, if_id_pc4, fetch_count;
    logic        if_id_valid, halted, misalign_err;

    int nvec = 0;
    int nmis = 0;

    logic [31:0] mem [42];

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a < 32'd168) return mem[a / 4];
        return 32'hFFFF_FFFF;
    endfunction

    assign imem_instr = mem_read(imem_addr);

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic st, input logic bt,
                              input logic [31:0] btgt, input logic j, input logic [31:0] jtgt);
        logic [31:0] t;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
        end else if (bt || j) begin
            t = bt ? btgt : jtgt;
            if (t % 4 != 0) m_mis = 1;
            m_pc = t - (t % 4);
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (st) begin
            // everything holds
        end else if (m_pc >= 168) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else begin
            m_instr = mem_read(m_pc);
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
            m_pc    = m_pc + 4;
        end
    endtask

    task automatic tick(input logic rst, input logic st, input logic bt,
                        input logic [31:0] btgt, input logic j, input logic [31:0] jtgt);
        reset = rst; stall = st; branch_taken = bt; branch_target = btgt;
        jump = j; jump_target = jtgt;
        model_step(rst, st, bt, btgt, j, jtgt);
        @(posedge clk);
        #1;
        check("imem_addr", imem_addr, m_pc);
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc4", if_id_pc4, m_pc4);
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        check("halted", {31'b0, halted}, {31'b0, (m_pc >= 32'd168)});
        check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        check("fetch_count", fetch_count, m_cnt);
    endtask

    typedef struct {
        logic        rst, st, bt;
        logic [31:0] btgt;
        logic        j;
        logic [31:0] jtgt;
        logic [31:0] e_pc, e_pc4, e_cnt;
        logic        e_valid, e_mis;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic st, input logic bt, input logic [31:0] btgt,
                                input logic j, input logic [31:0] jtgt, input logic [31:0] e_pc,
                                input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt,
                                input logic e_mis);
        vec_t v;
        v.rst = rst; v.st = st; v.bt = bt; v.btgt = btgt; v.j = j; v.jtgt = jtgt;
        v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_cnt = e_cnt; v.e_mis = e_mis;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [31:0] exp_instr;
        int          budget;
        logic        r, s, b, jj;
        logic [31:0] bt_t, j_t;

        for (int i = 0; i < 42; i++) mem[i] = $urandom;
        reset = 1; stall = 0; branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0;

        //            rst st bt btgt   j  jtgt   pc     pc4    v  cnt mis
        tbl.push_back(mk(1, 0, 0, 0,     0, 0,     32'h00, 32'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,     0, 0,     32'h00, 32'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0,     32'h04, 32'h04, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0,     32'h08, 32'h08, 1, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0,     0, 0,     32'h08, 32'h08, 1, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0,     0, 0,     32'h08, 32'h08, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0,     32'h0C, 32'h0C, 1, 3, 0));
        tbl.push_back(mk(0, 0, 1, 32'h20, 0, 0,    32'h20, 32'h00, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0,     32'h24, 32'h24, 1, 4, 0));
        tbl.push_back(mk(0, 1, 1, 32'h40, 1, 32'h80, 32'h40, 32'h00, 0, 4, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0,     32'h44, 32'h44, 1, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 32'h13, 32'h10, 32'h00, 0, 5, 1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h14 + 4*k, 32'h14 + 4*k, 1, 6 + k, 1));

        @(negedge clk);
        foreach (tbl[i]) begin
            tick(tbl[i].rst, tbl[i].st, tbl[i].bt, tbl[i].btgt, tbl[i].j, tbl[i].jtgt);
            exp_instr = tbl[i].e_valid ? mem[(tbl[i].e_pc4 - 4) / 4] : 32'h0;
            check("tbl_pc", imem_addr, tbl[i].e_pc);
            check("tbl_pc4", if_id_pc4, tbl[i].e_pc4);
            check("tbl_valid", {31'b0, if_id_valid}, {31'b0, tbl[i].e_valid});
            check("tbl_instr", if_id_instr, exp_instr);
            check("tbl_count", fetch_count, tbl[i].e_cnt);
            check("tbl_misalign", {31'b0, misalign_err}, {31'b0, tbl[i].e_mis});
        end

        // run to end of program
        budget = 0;
        while (imem_addr != 32'd164 && budget < 100) begin
            tick(0, 0, 0, 0, 0, 0);
            budget++;
        end
        check("reach_164", imem_addr, 32'd164);
        tick(0, 0, 0, 0, 0, 0);
        check("end_pc", imem_addr, 32'd168);
        check("end_halted", {31'b0, halted}, 32'd1);
        check("end_last_word", if_id_instr, mem[41]);
        tick(0, 0, 0, 0, 0, 0);
        check("halt_pc_hold", imem_addr, 32'd168);
        check("halt_bubble", {31'b0, if_id_valid}, 32'd0);
        tick(0, 0, 0, 0, 0, 0);
        check("halt_pc_hold2", imem_addr, 32'd168);
        tick(0, 0, 0, 0, 1, 32'h0);
        check("unhalt_pc", imem_addr, 32'd0);
        check("unhalt", {31'b0, halted}, 32'd0);
        tick(0, 1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        check("rst_pc", imem_addr, 32'd0);
        check("rst_instr", if_id_instr, 32'd0);
        check("rst_valid", {31'b0, if_id_valid}, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
        check("rst_count", fetch_count, 32'd0);

        // randomized run against the model
        for (int n = 0; n < 400; n++) begin
            r    = ($urandom_range(0, 49) == 0);
            s    = ($urandom_range(0, 3) == 0);
            b    = ($urandom_range(0, 9) == 0);
            jj   = ($urandom_range(0, 9) == 0);
            bt_t = $urandom_range(0, 200);
            j_t  = $urandom_range(0, 200);
            tick(r, s, b, bt_t, jj, j_t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
